// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters.
// Define ALU_OP_CHECK_EN to answer opcodes 100/101/110 directly with rsp_err set.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Requesters hold valid and operands until ready; the consumer may stall with rsp_ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic             last_grant;
    logic             cur_id;
    logic             grant;
    logic             any_valid;
    logic             accept;
    logic             sel_illegal;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    // A lone requester wins outright; on a tie the one not served last wins.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign any_valid  = req0_valid | req1_valid;
    assign req0_ready = rst_n && (state == IDLE) && any_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && any_valid && grant;
    assign accept     = req0_ready | req1_ready;
    assign sel_a      = grant ? req1_a  : req0_a;
    assign sel_b      = grant ? req1_b  : req0_b;
    assign sel_op     = grant ? req1_op : req0_op;

`ifdef ALU_OP_CHECK_EN
    assign sel_illegal = (sel_op == 3'b100) || (sel_op == 3'b101) || (sel_op == 3'b110);
`else
    assign sel_illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_id     <= grant;
                        last_grant <= grant;
                        rsp_err    <= sel_illegal;
                        if (sel_illegal) begin
                            // Illegal opcode never reaches the ALU; answer straight away.
                            rsp_id    <= grant;
                            rsp_data  <= '0;
                            rsp_zero  <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a       <= sel_a;
                            alu_b       <= sel_b;
                            alu_control <= sel_op;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= 3'(ALU_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        rsp_data  <= alu_result;
                        rsp_zero  <= (alu_result == '0);
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, directed corner sequences,
// and randomized traffic checked by a cycle-level reference model and scoreboard.
module tb_alu_share_arbiter;
    localparam int W = 32;
    localparam int L = 2;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_control;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [W-1:0] rsp_data;

    int errors = 0;
    int checks = 0;

    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b111:  return a * b;
            default: return '0;
        endcase
    endfunction

    function automatic logic short_circuit(input logic [2:0] op);
`ifdef ALU_OP_CHECK_EN
        return (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
`else
        return 1'b0;
`endif
    endfunction

    // External registered ALU with L edges of latency.
    logic [W-1:0] alu_pipe [L];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) alu_pipe[i] <= '0;
        end else begin
            alu_pipe[0] <= alu_ref(alu_control, alu_a, alu_b);
            for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
        end
    end
    assign alu_result = alu_pipe[L-1];

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic         id;
        logic         err;
        logic         zero;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t         exp_q[$];
    rsp_t         got_q[$];
    int           acc_q[$];
    int           cyc = 0;
    logic         mbusy = 1'b0;
    int           due = 0;
    logic         prefer = 1'b0;
    logic [W-1:0] ea = '0, eb = '0;
    logic [2:0]   ec = '0;

    initial begin
        logic er0, er1, ev, nid, bad;
        logic [2:0] nop;
        logic [W-1:0] na, nb, nd;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (!rst_n) begin
                mbusy = 1'b0;
                prefer = 1'b0;
                exp_q.delete();
                ea = '0; eb = '0; ec = '0;
                chk("reset_ctrl", {rsp_valid, rsp_id, rsp_zero, rsp_err, req0_ready, req1_ready, alu_control}, '0);
                chk("reset_data", {rsp_data, alu_a, alu_b}, '0);
            end else begin
                er0 = !mbusy && req0_valid && (!req1_valid || prefer == 1'b0);
                er1 = !mbusy && req1_valid && (!req0_valid || prefer == 1'b1);
                chk("ready", {req0_ready, req1_ready}, {er0, er1});
                ev = mbusy && (cyc >= due);
                chk("rsp_valid", rsp_valid, ev);
                chk("alu_inputs", {alu_control, alu_a, alu_b}, {ec, ea, eb});
                if (ev && rsp_valid && exp_q.size() > 0) begin
                    chk("rsp_fields", {rsp_id, rsp_err, rsp_zero, rsp_data}, exp_q[0]);
                    if (rsp_ready) begin
                        got_q.push_back({rsp_id, rsp_err, rsp_zero, rsp_data});
                        void'(exp_q.pop_front());
                        mbusy = 1'b0;
                    end
                end
                if (er0 || er1) begin
                    nid = er1;
                    nop = nid ? req1_op : req0_op;
                    na  = nid ? req1_a  : req0_a;
                    nb  = nid ? req1_b  : req0_b;
                    bad = short_circuit(nop);
                    nd  = bad ? '0 : alu_ref(nop, na, nb);
                    exp_q.push_back({nid, bad, (nd == '0), nd});
                    mbusy  = 1'b1;
                    due    = cyc + (bad ? 1 : L + 2);
                    prefer = ~nid;
                    acc_q.push_back(cyc);
                    if (!bad) begin
                        ea = na; eb = nb; ec = nop;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic id, input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Presents a request, holds it until accepted, returns on the negedge after the accept edge.
    task automatic issue(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic got;
        int n;
        got = 1'b0;
        n = 0;
        @(negedge clk);
        drive(id, 1'b1, op, a, b);
        while (!got && n < 60) begin
            #4;
            got = id ? req1_ready : req0_ready;
            @(negedge clk);
            n++;
        end
        drive(id, 1'b0, 3'b000, '0, '0);
        chk("accept_timeout", got, 1'b1);
    endtask

    // Called right after issue(); lat counts cycles from the accept cycle to rsp_valid.
    task automatic wait_rsp(output logic id, output logic [W-1:0] data, output logic zero, output logic err, output int lat);
        logic seen;
        seen = 1'b0;
        lat = 1;
        id = 1'b0; data = '0; zero = 1'b0; err = 1'b0;
        while (!seen && lat < 40) begin
            #4;
            if (rsp_valid) begin
                seen = 1'b1;
                id = rsp_id; data = rsp_data; zero = rsp_zero; err = rsp_err;
            end
            @(negedge clk);
            if (!seen) lat++;
        end
        chk("rsp_timeout", seen, 1'b1);
    endtask

    task automatic wait_got(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("got_timeout", (got_q.size() >= n), 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic         id;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic         rid, rz, re, pend0, pend1;
        logic [W-1:0] rd;
        int           lat, t, exp_lat;
        logic [2:0]   exp_ctrl, op_pick;
        logic         exp_err;
        logic [2:0]   legal_ops[5];

        legal_ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
        vecs[0] = '{1'b0, 3'b010, 32'd7,          32'd5,          32'd12,         1'b0};
        vecs[1] = '{1'b1, 3'b011, 32'd5,          32'd5,          32'd0,          1'b1};
        vecs[2] = '{1'b1, 3'b111, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1};
        vecs[3] = '{1'b0, 3'b000, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0};
        vecs[4] = '{1'b1, 3'b001, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0};
        vecs[5] = '{1'b0, 3'b011, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[6] = '{1'b1, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[7] = '{1'b0, 3'b111, 32'd3,          32'd4,          32'd12,         1'b0};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        drive(1'b1, 1'b0, 3'b000, '0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one requester at a time.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_rsp(rid, rd, rz, re, lat);
            chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            chk($sformatf("vec%0d_zero", i), rz, vecs[i].exp_zero);
            chk($sformatf("vec%0d_id", i), rid, vecs[i].id);
            chk($sformatf("vec%0d_err", i), re, 1'b0);
            chk($sformatf("vec%0d_latency", i), lat, L + 2);
        end

        // Simultaneous requests after reset: req0 first, then req1, then req0 first again.
        do_reset();
        got_q.delete();
        acc_q.delete();
        fork
            issue(1'b0, 3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
            issue(1'b1, 3'b111, 32'd3, 32'd4);
        join
        wait_got(2);
        chk("arb_first_id", got_q[0].id, 1'b0);
        chk("arb_first_data", got_q[0].data, 32'h0000_00F0);
        chk("arb_second_id", got_q[1].id, 1'b1);
        chk("arb_second_data", got_q[1].data, 32'd12);
        chk("accept_spacing", acc_q[1] - acc_q[0], L + 3);
        fork
            issue(1'b0, 3'b001, 32'd1, 32'd2);
            issue(1'b1, 3'b010, 32'd10, 32'd20);
        join
        wait_got(4);
        chk("arb_pair2_first_id", got_q[2].id, 1'b0);
        chk("arb_pair2_first_data", got_q[2].data, 32'd3);
        chk("arb_pair2_second_id", got_q[3].id, 1'b1);
        chk("arb_pair2_second_data", got_q[3].data, 32'd30);

        // Consumer stall in RESP while the other requester waits.
        got_q.delete();
        rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'd100, 32'd23);
        fork
            issue(1'b1, 3'b011, 32'd50, 32'd8);
        join_none
        t = 0;
        #4;
        while (!rsp_valid && t < 40) begin
            @(negedge clk);
            #4;
            t++;
        end
        chk("stall_rsp_seen", rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_data", rsp_data, 32'd123);
            chk("stall_ready", {req0_ready, req1_ready}, 2'b00);
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #4;
        chk("stall_single_handshake", got_q.size(), 1);
        chk("stall_valid_dropped", rsp_valid, 1'b0);
        wait fork;
        wait_got(2);
        chk("stall_next_id", got_q[1].id, 1'b1);
        chk("stall_next_data", got_q[1].data, 32'd42);

        // Reset while the operation sits in WAIT.
        got_q.delete();
        issue(1'b0, 3'b010, 32'd9, 32'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_ctrl", {rsp_valid, rsp_id, rsp_zero, rsp_err, req0_ready, req1_ready, alu_control}, '0);
        chk("midreset_data", {rsp_data, alu_a, alu_b}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale_rsp", got_q.size(), 0);
        issue(1'b0, 3'b010, 32'd1, 32'd1);
        wait_rsp(rid, rd, rz, re, lat);
        chk("post_reset_data", rd, 32'd2);
        chk("post_reset_id", rid, 1'b0);

        // Opcode 101: short-circuit with the check, plain issue without it.
`ifdef ALU_OP_CHECK_EN
        exp_err = 1'b1; exp_lat = 1;     exp_ctrl = 3'b010;
`else
        exp_err = 1'b0; exp_lat = L + 2; exp_ctrl = 3'b101;
`endif
        issue(1'b1, 3'b101, 32'd5, 32'd6);
        wait_rsp(rid, rd, rz, re, lat);
        chk("illegal_err", re, exp_err);
        chk("illegal_data", rd, 32'd0);
        chk("illegal_zero", rz, 1'b1);
        chk("illegal_id", rid, 1'b1);
        chk("illegal_latency", lat, exp_lat);
        chk("illegal_alu_control", alu_control, exp_ctrl);
        issue(1'b0, 3'b010, 32'd2, 32'd3);
        wait_rsp(rid, rd, rz, re, lat);
        chk("after_illegal_data", rd, 32'd5);
        chk("after_illegal_err", re, 1'b0);

        // Randomized traffic on both ports with random consumer back-pressure.
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (pend0) req0_valid = 1'b0;
            if (pend1) req1_valid = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (((p == 0) ? !req0_valid : !req1_valid) && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 4) == 0) op_pick = 3'($urandom_range(4, 6));
                    else op_pick = legal_ops[$urandom_range(0, 4)];
                    rd = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
                    drive(p[0], 1'b1, op_pick, rd,
                          ($urandom_range(0, 3) == 0) ? rd : W'($urandom));
                end
            end
            #4;
            pend0 = req0_valid && req0_ready;
            pend1 = req1_valid && req1_ready;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, '0, '0);
        drive(1'b1, 1'b0, 3'b000, '0, '0);
        rsp_ready = 1'b1;
        t = 0;
        while (mbusy && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain_idle", mbusy, 1'b0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
